// File: rtl/fq_ptr_arbiter.sv
// fq_ptr_arbiter: shares one free-pointer queue between N_PORT alloc
// requesters (pop side) and N_PORT release requesters (push side).
// Each side is an independent round-robin arbiter that issues at most one
// grant per cycle. The block also tracks pointers in use, raises a
// registered low-watermark flag and latches double-free errors.
module fq_ptr_arbiter #(
  parameter int N_PORT = 4,
  parameter int PTR_W  = 10,
  parameter int LOW_WM = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORT-1:0]        alloc_req,
  output logic [N_PORT-1:0]        alloc_ack,
  output logic [PTR_W-1:0]         alloc_ptr,
  input  logic [N_PORT-1:0]        rel_req,
  input  logic [N_PORT*PTR_W-1:0]  rel_ptr,
  output logic [N_PORT-1:0]        rel_ack,
  output logic                     fq_rd,
  input  logic [PTR_W-1:0]         fq_ptr_dout,
  input  logic                     fq_empty,
  output logic                     fq_wr,
  output logic [15:0]              fq_ptr_din,
  input  logic                     fq_act,
  input  logic [PTR_W-1:0]         fq_count,
  output logic                     fq_low,
  output logic [PTR_W:0]           inuse_cnt,
  output logic                     err_dfree
);

  localparam int IDX_W = $clog2(N_PORT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic             run;
  logic [IDX_W-1:0] arr_ptr, rel_rr_ptr;
  logic [IDX_W:0]   a_pick, r_pick;
  logic [IDX_W-1:0] a_idx, r_idx;
  logic             a_gnt, r_gnt;

  // Returns {valid, index} of the first set bit of elig at or after start,
  // wrapping modulo N_PORT. Scanning downwards lets the nearest port win.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_PORT-1:0] elig,
                                             input logic [IDX_W-1:0]  start);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_PORT - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_PORT;
      if (elig[idx]) res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

  // Round-robin pointer advance: one past the granted port, wrapping to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_PORT - 1)) ? '0 : g + 1'b1;
  endfunction

  // State register: INIT after reset, RUN once the free queue is ready.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is always written with <= so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Next state: leave INIT on the first cycle the free queue reports active.
  always_comb begin
    // NOTE: a default assignment first means every path drives state_nxt,
    // so no latch can be inferred.
    state_nxt = state;
    if (state == ST_INIT && fq_act) state_nxt = ST_RUN;
  end

  // FSM output: grants are enabled only in RUN and never during reset.
  always_comb begin
    run = (state == ST_RUN) && !rst;
  end

  // Both arbiters mask ports acked this cycle so they cannot be regranted.
  always_comb begin
    a_pick = rr_pick(alloc_req & ~alloc_ack, arr_ptr);
    r_pick = rr_pick(rel_req & ~rel_ack, rel_rr_ptr);
    a_idx  = a_pick[IDX_W-1:0];
    r_idx  = r_pick[IDX_W-1:0];
    a_gnt  = run && !fq_empty && a_pick[IDX_W];
    r_gnt  = run && r_pick[IDX_W];
  end

  // Queue strobes and push data follow the grants in the same cycle.
  always_comb begin
    fq_rd      = a_gnt;
    fq_wr      = r_gnt;
    fq_ptr_din = '0;
    if (r_gnt) fq_ptr_din[PTR_W-1:0] = rel_ptr[int'(r_idx)*PTR_W +: PTR_W];
  end

  // Registered acks, pointer, round-robin state, counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ack  <= '0;
      alloc_ptr  <= '0;
      rel_ack    <= '0;
      arr_ptr    <= '0;
      rel_rr_ptr <= '0;
      inuse_cnt  <= '0;
      err_dfree  <= 1'b0;
      fq_low     <= 1'b0;
    end else begin
      alloc_ack <= '0;
      rel_ack   <= '0;
      fq_low    <= (state == ST_RUN) && (32'(fq_count) < LOW_WM);

      if (a_gnt) begin
        alloc_ack[a_idx] <= 1'b1;
        alloc_ptr        <= fq_ptr_dout;
        arr_ptr          <= next_idx(a_idx);
      end

      if (r_gnt) begin
        rel_ack[r_idx] <= 1'b1;
        rel_rr_ptr     <= next_idx(r_idx);
        // A release with nothing outstanding is still honoured, but flagged.
        if (inuse_cnt == '0) err_dfree <= 1'b1;
      end

      unique case ({a_gnt, r_gnt})
        2'b10:   inuse_cnt <= inuse_cnt + 1'b1;
        2'b01:   if (inuse_cnt != '0) inuse_cnt <= inuse_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fq_ptr_arbiter.sv
// tb_fq_ptr_arbiter: drives fq_ptr_arbiter with a queue-based free-queue
// environment, directed scenarios and randomized requesters. A transaction
// level model predicts every output each cycle; directed phases add
// hand-computed literal expectations.
module tb_fq_ptr_arbiter;

  localparam int N      = 4;
  localparam int PW     = 10;
  localparam int LOW_WM = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    alloc_req, alloc_ack, rel_req, rel_ack;
  logic [PW-1:0]   alloc_ptr, fq_ptr_dout, fq_count;
  logic [N*PW-1:0] rel_ptr;
  logic            fq_rd, fq_empty, fq_wr, fq_act, fq_low, err_dfree;
  logic [15:0]     fq_ptr_din;
  logic [PW:0]     inuse_cnt;

  always #5 clk = ~clk;

  fq_ptr_arbiter #(.N_PORT(N), .PTR_W(PW), .LOW_WM(LOW_WM)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_ptr(alloc_ptr),
    .rel_req(rel_req), .rel_ptr(rel_ptr), .rel_ack(rel_ack),
    .fq_rd(fq_rd), .fq_ptr_dout(fq_ptr_dout), .fq_empty(fq_empty),
    .fq_wr(fq_wr), .fq_ptr_din(fq_ptr_din), .fq_act(fq_act),
    .fq_count(fq_count), .fq_low(fq_low), .inuse_cnt(inuse_cnt),
    .err_dfree(err_dfree)
  );

  int checks   = 0;
  int failures = 0;

  // Requester and environment state, applied to the DUT at each negedge.
  bit [N-1:0] a_req, r_req;
  int         r_val [N];
  bit         rst_in, act_in;
  int         env_q [$];
  int         env_depth;
  int         pool [$];

  // Behavioural model: what the outputs must be after the last edge.
  bit         m_run;
  bit [N-1:0] m_aack, m_rack;
  int         m_aptr, m_arr, m_rrr, m_inuse;
  bit         m_err, m_low;
  int         m_ag, m_rg;

  // DUT combinational outputs captured mid-cycle by step().
  bit s_rd, s_wr;
  int s_din, s_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic env_load(input int base, input int n);
    env_q.delete();
    for (int i = 0; i < n; i++) env_q.push_back(base + i);
  endtask

  // Randomized requesters: alloc ports raise requests at will and may keep
  // them after an ack; release ports return pointers previously handed out.
  task automatic rand_requesters();
    int idx;
    if (m_aack != '0) pool.push_back(m_aptr);
    for (int i = 0; i < N; i++) begin
      if (m_aack[i]) begin
        if ($urandom_range(1, 0) == 0) a_req[i] = 1'b0;
      end else if (!a_req[i] && $urandom_range(2, 0) == 0) begin
        a_req[i] = 1'b1;
      end
      if (m_rack[i]) begin
        r_req[i] = 1'b0;
      end else if (!r_req[i] && pool.size() > 0 && $urandom_range(3, 0) == 0) begin
        idx      = $urandom_range(pool.size() - 1, 0);
        r_val[i] = pool[idx];
        pool.delete(idx);
        r_req[i] = 1'b1;
      end
    end
  endtask

  // Which port each side must grant this cycle, from the arbitration rules.
  task automatic model_comb();
    int p;
    m_ag = -1;
    m_rg = -1;
    if (m_run && !rst_in) begin
      for (int k = 0; k < N; k++) begin
        p = (m_arr + k) % N;
        if (m_ag < 0 && env_q.size() > 0 && a_req[p] && !m_aack[p]) m_ag = p;
        p = (m_rrr + k) % N;
        if (m_rg < 0 && r_req[p] && !m_rack[p]) m_rg = p;
      end
    end
  endtask

  // Apply this cycle's grants to the model and the free-queue environment.
  task automatic model_seq();
    if (rst_in) begin
      m_run = 0; m_aack = '0; m_rack = '0; m_aptr = 0; m_arr = 0; m_rrr = 0;
      m_inuse = 0; m_err = 0; m_low = 0;
      env_load(0, env_depth);
      pool.delete();
      a_req = '0;
      r_req = '0;
    end else begin
      m_low  = m_run && (s_count < LOW_WM);
      m_aack = '0;
      m_rack = '0;
      if (m_ag >= 0) begin
        m_aack[m_ag] = 1'b1;
        m_aptr       = env_q.pop_front();
        m_arr        = (m_ag + 1) % N;
      end
      if (m_rg >= 0) begin
        m_rack[m_rg] = 1'b1;
        env_q.push_back(r_val[m_rg]);
        m_rrr = (m_rg + 1) % N;
        if (m_inuse == 0) m_err = 1'b1;
      end
      if (m_ag >= 0 && m_rg < 0) m_inuse++;
      else if (m_rg >= 0 && m_ag < 0 && m_inuse > 0) m_inuse--;
      if (act_in) m_run = 1'b1;
    end
  endtask

  // One clock cycle: drive at negedge, compare everything, update at posedge.
  task automatic step(input bit rnd);
    @(negedge clk);
    if (rnd) rand_requesters();
    rst       = rst_in;
    fq_act    = act_in;
    alloc_req = a_req;
    rel_req   = r_req;
    for (int i = 0; i < N; i++) rel_ptr[i*PW +: PW] = PW'(r_val[i]);
    s_count     = env_q.size();
    fq_empty    = (s_count == 0);
    fq_ptr_dout = (s_count == 0) ? '0 : PW'(env_q[0]);
    fq_count    = PW'(s_count);
    #1;
    model_comb();
    check("alloc_ack", alloc_ack, m_aack);
    if (m_aack != '0) check("alloc_ptr", alloc_ptr, m_aptr);
    check("rel_ack", rel_ack, m_rack);
    check("inuse_cnt", inuse_cnt, m_inuse);
    check("err_dfree", err_dfree, m_err);
    check("fq_low", fq_low, m_low);
    check("fq_rd", fq_rd, m_ag >= 0);
    check("fq_wr", fq_wr, m_rg >= 0);
    check("fq_ptr_din", fq_ptr_din, (m_rg >= 0) ? r_val[m_rg] : 0);
    s_rd  = fq_rd;
    s_wr  = fq_wr;
    s_din = fq_ptr_din;
    @(posedge clk);
    model_seq();
  endtask

  initial begin
    bit found;

    rst = 1'b1; fq_act = 1'b0; alloc_req = '0; rel_req = '0; rel_ptr = '0;
    fq_ptr_dout = '0; fq_empty = 1'b1; fq_count = '0;
    rst_in = 1'b1; act_in = 1'b0; a_req = '0; r_req = '0;
    for (int i = 0; i < N; i++) r_val[i] = 0;
    env_depth = 512;
    env_load(0, env_depth);
    m_run = 0; m_aack = '0; m_rack = '0; m_aptr = 0; m_arr = 0; m_rrr = 0;
    m_inuse = 0; m_err = 0; m_low = 0;

    // Reset, then the free queue comes up at cycle 5 with port 0 waiting.
    step(0);
    step(0);
    #1;
    check("rst_alloc_ptr", alloc_ptr, 0);
    check("rst_inuse", inuse_cnt, 0);
    rst_in = 1'b0;
    a_req  = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      act_in = (c == 5);
      step(0);
      check("t1_no_rd_in_init", s_rd, 0);
    end
    step(0);
    check("t1_first_rd", s_rd, 1);
    #1;
    check("t1_ack", alloc_ack, 4'b0001);
    check("t1_ptr", alloc_ptr, 0);
    a_req = '0;

    // Fresh start, all four ports requesting continuously.
    rst_in = 1'b1;
    step(0);
    rst_in = 1'b0;
    a_req  = 4'b1111;
    step(0);
    for (int i = 0; i < 8; i++) begin
      step(0);
      #1;
      check("t2_ack_rotate", alloc_ack, 4'b0001 << (i % 4));
      check("t2_ptr_seq", alloc_ptr, i);
    end
    check("t2_inuse_8", inuse_cnt, 8);
    a_req = '0;
    step(0);

    // Empty queue: alloc waits until a release refills it.
    env_q.delete();
    a_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(0);
      check("t3_no_rd_empty", s_rd, 0);
      #1;
      check("t3_no_ack_empty", alloc_ack, 0);
    end
    r_req    = 4'b0010;
    r_val[1] = 5;
    step(0);
    check("t3_wr", s_wr, 1);
    check("t3_din", s_din, 5);
    #1;
    check("t3_rel_ack", rel_ack, 4'b0010);
    r_req = '0;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      step(0);
      #1;
      if (alloc_ack[2]) begin
        found = 1;
        check("t3_alloc_ptr", alloc_ptr, 5);
      end
    end
    check("t3_alloc_served", found, 1);
    a_req = '0;

    // Simultaneous alloc on port 0 and release on port 3.
    env_load(100, 100);
    a_req    = 4'b0001;
    r_req    = 4'b1000;
    r_val[3] = 'h1A;
    step(0);
    check("t4_rd", s_rd, 1);
    check("t4_wr", s_wr, 1);
    check("t4_din", s_din, 'h1A);
    #1;
    check("t4_rel_ack", rel_ack, 4'b1000);
    check("t4_alloc_ack", alloc_ack, 4'b0001);
    check("t4_alloc_ptr", alloc_ptr, 100);
    check("t4_inuse_same", inuse_cnt, 8);
    a_req = '0;
    r_req = '0;

    // Double free right after reset.
    rst_in = 1'b1;
    step(0);
    rst_in = 1'b0;
    step(0);
    r_req    = 4'b0010;
    r_val[1] = 'h33;
    step(0);
    #1;
    check("t5_rel_ack", rel_ack, 4'b0010);
    check("t5_err", err_dfree, 1);
    check("t5_inuse_0", inuse_cnt, 0);
    r_req = '0;
    for (int i = 0; i < 3; i++) step(0);
    #1;
    check("t5_err_sticky", err_dfree, 1);

    // Low watermark crossing 33 -> 32 -> 31, then reset mid-burst.
    env_load(0, 33);
    a_req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step(0);
      #1;
      if (s_count == 32) check("t6_low_at_32", fq_low, 0);
      if (s_count == 31) check("t6_low_at_31", fq_low, 1);
    end
    rst_in = 1'b1;
    step(0);
    check("t6_rd_in_rst", s_rd, 0);
    #1;
    check("t6_rst_alloc_ack", alloc_ack, 0);
    check("t6_rst_alloc_ptr", alloc_ptr, 0);
    check("t6_rst_rel_ack", rel_ack, 0);
    check("t6_rst_inuse", inuse_cnt, 0);
    check("t6_rst_err", err_dfree, 0);
    check("t6_rst_low", fq_low, 0);
    check("t6_rst_fq_rd", fq_rd, 0);
    check("t6_rst_fq_wr", fq_wr, 0);
    check("t6_rst_din", fq_ptr_din, 0);

    // Random traffic on a small pointer pool so the queue empties and refills.
    env_depth = 48;
    step(0);
    rst_in = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst_in = ($urandom_range(599, 0) == 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
